uart_tx_queue: RTL and testbench

- Byte queue and handshake sequencer directly upstream of the UART transmitter.
- Accepts bytes from design logic via single-cycle write strobes and buffers them in a synchronous FIFO.
- Drains them one at a time into the transmitter using its level-start / busy protocol:
  - tx_start held high until busy is seen.
  - tx_start dropped before the next byte is requested, so the transmitter re-arms.
- Lets producers (message formatters, result printers) burst strings without tracking UART timing.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_queue_if.sv | 53 +++++
 rtl/sync_fifo_byte.sv | 85 ++++++++
 rtl/uart_tx_queue.sv | 100 ++++++++++
 tb/tb_uart_tx_queue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit-side blocks.
//   - DEFAULT_TXQ_DEPTH : default number of entries in the transmit byte queue
//   - txq_state_t       : states of the transmit-queue handshake sequencer
package uart_pkg;

  localparam int DEFAULT_TXQ_DEPTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if
//   Bundles the producer write port and the transmitter handshake of
//   uart_tx_queue.
//   Producer side : wr_en, wr_data, flush (in); full, empty, count (out)
//   Transmitter   : tx_start, tx_data (out); tx_busy (in)
//   Optional (UART_TX_QUEUE_OVF_EN): ovf, drop_cnt (out); ovf_clr (in)
//   Modport "slave" is the queue itself; "master" is whatever drives it
//   (producer logic plus transmitter, or a testbench).
interface uart_tx_queue_if
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TXQ_DEPTH
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic            wr_en;
  logic [7:0]      wr_data;
  logic            flush;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;

`ifdef UART_TX_QUEUE_OVF_EN
  logic            ovf;
  logic [7:0]      drop_cnt;
  logic            ovf_clr;

  modport slave (
    input  wr_en, wr_data, flush, tx_busy, ovf_clr,
    output full, empty, count, tx_start, tx_data, ovf, drop_cnt
  );

  modport master (
    output wr_en, wr_data, flush, tx_busy, ovf_clr,
    input  full, empty, count, tx_start, tx_data, ovf, drop_cnt
  );
`else
  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, count, tx_start, tx_data
  );

  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, count, tx_start, tx_data
  );
`endif

endinterface

// File: rtl/sync_fifo_byte.sv
// sync_fifo_byte
//   Synchronous byte FIFO: circular buffer of DEPTH x 8 with wrapping
//   read/write pointers and registered occupancy flags.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset
//     push, push_data  : enqueue strobe and byte (ignored while full)
//     pop              : dequeue strobe (ignored while empty)
//     flush            : synchronous clear, wins over push
//     head             : byte at the read pointer
//     full, empty      : registered flags
//     count            : occupancy 0..DEPTH
module sync_fifo_byte
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEFAULT_TXQ_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [7:0]      push_data,
  input  logic            pop,
  input  logic            flush,
  output logic [7:0]      head,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              do_push;
  logic              do_pop;

  // The full test uses the registered flag, so a push is refused even when a
  // pop frees a slot in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + (ADDR_W+1)'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - (ADDR_W+1)'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (ADDR_W+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Byte queue in front of the UART transmitter. Producers write bytes with
//   single-cycle strobes; a three-state sequencer hands them one at a time to
//   the transmitter using its level-start / busy handshake.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : uart_tx_queue_if.slave (write port, status, tx handshake)
//   Optional feature, enabled by defining UART_TX_QUEUE_OVF_EN:
//     bus.ovf (sticky dropped-write flag), bus.drop_cnt (saturating drop
//     count), bus.ovf_clr (clears both; wins over a simultaneous drop).
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TXQ_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_queue_if.slave bus
);

  txq_state_t state;
  logic [7:0] head;
  logic       pop;

  // A byte only leaves the queue from idle while the transmitter is free,
  // so a request can never be raised on top of a busy transmitter.
  assign pop = (state == S_IDLE) && !bus.empty && !bus.tx_busy;

  sync_fifo_byte #(
    .DEPTH (DEPTH)
  ) fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .flush     (bus.flush),
    .head      (head),
    .full      (bus.full),
    .empty     (bus.empty),
    .count     (bus.count)
  );

  // tx_start stays low for all of S_WAIT so the transmitter sees it drop
  // and re-arms before the next request. Flush never touches this FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            bus.tx_data  <= head;
            bus.tx_start <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.tx_busy) begin
            bus.tx_start <= 1'b0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.tx_busy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          bus.tx_start <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_QUEUE_OVF_EN
  logic drop;

  assign drop = bus.wr_en && bus.full && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ovf      <= 1'b0;
      bus.drop_cnt <= 8'h00;
    end else if (bus.ovf_clr) begin
      bus.ovf      <= 1'b0;
      bus.drop_cnt <= 8'h00;
    end else if (drop) begin
      bus.ovf <= 1'b1;
      if (bus.drop_cnt != 8'hFF) begin
        bus.drop_cnt <= bus.drop_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
//   Self-checking bench for uart_tx_queue. The bench plays the UART
//   transmitter (BAUD_DIV=10 clocks per bit) and decodes its own line back
//   into bytes. A queue-based reference model tracks what the FIFO must hold
//   and which byte each new request must present.
//   Define UART_TX_QUEUE_OVF_EN to also exercise the overflow reporting.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH    = DEFAULT_TXQ_DEPTH;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int BAUD_DIV = 10;

  typedef struct {
    logic [7:0]      data;
    logic [ADDR_W:0] exp_count;
    logic [7:0]      exp_tx_data;
  } lat_vec_t;

  logic clk;
  logic rst_n;
  logic xmit_busy;
  logic force_busy;
  logic tx_enable;
  logic line;

  int checks      = 0;
  int errors      = 0;
  int start_count = 0;
  int busy_pulses = 0;

  logic [7:0] model_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] held_data;
  logic       prev_start;
  logic       model_ovf;
  logic [7:0] model_drop;

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.tx_busy = xmit_busy | force_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive_write(input logic [7:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = data;
  endtask

  task automatic end_write();
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(model_q.size() == 0 && !bus.tx_busy && !bus.tx_start && line) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_done", 32'(n < budget), 1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check_output({name, "_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      check_output(name, rx_q[i], exp[i]);
    end
    rx_q.delete();
  endtask

  // Transmitter model: accepts a request only once tx_start has been seen
  // low since the previous byte, holds busy for a full 10-bit frame.
  initial begin
    logic       armed;
    logic [9:0] frame;
    xmit_busy = 1'b0;
    line      = 1'b1;
    armed     = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.tx_start) begin
        armed = 1'b1;
      end else if (tx_enable && armed && !xmit_busy) begin
        frame     = {1'b1, bus.tx_data, 1'b0};
        armed     = 1'b0;
        xmit_busy = 1'b1;
        busy_pulses++;
        for (int b = 0; b < 10; b++) begin
          line = frame[b];
          repeat (BAUD_DIV) @(negedge clk);
        end
        xmit_busy = 1'b0;
      end
    end
  end

  // Line receiver: samples mid-bit, LSB first.
  initial begin
    logic [7:0] rxb;
    rxb = 8'h00;
    forever begin
      @(posedge clk);
      if (line == 1'b0) begin
        repeat (BAUD_DIV / 2) @(posedge clk);
        check_output("start_bit", line, 0);
        for (int b = 0; b < 8; b++) begin
          repeat (BAUD_DIV) @(posedge clk);
          rxb[b] = line;
        end
        repeat (BAUD_DIV) @(posedge clk);
        check_output("stop_bit", line, 1);
        rx_q.push_back(rxb);
      end
    end
  end

  // Reference model, evaluated just after each rising edge using the inputs
  // that edge sampled. The queue holds exactly the accepted, not-yet-presented
  // bytes; every new request must carry its front entry.
  always @(posedge clk) begin
    int size_before;
    #1;
    if (!rst_n) begin
      model_q.delete();
      held_data  = 8'h00;
      prev_start = 1'b0;
      model_ovf  = 1'b0;
      model_drop = 8'h00;
    end else begin
      size_before = model_q.size();
      if (bus.tx_start && !prev_start) begin
        start_count++;
        check_output("start_while_busy", bus.tx_busy, 0);
        check_output("start_with_data", 32'(size_before != 0), 1);
        if (size_before != 0) begin
          held_data = model_q.pop_front();
        end
      end
      check_output("tx_data", bus.tx_data, held_data);
`ifdef UART_TX_QUEUE_OVF_EN
      if (bus.ovf_clr) begin
        model_ovf  = 1'b0;
        model_drop = 8'h00;
      end else if (bus.wr_en && !bus.flush && size_before == DEPTH) begin
        model_ovf = 1'b1;
        if (model_drop != 8'hFF) model_drop++;
      end
      check_output("ovf", bus.ovf, model_ovf);
      check_output("drop_cnt", bus.drop_cnt, model_drop);
`endif
      if (bus.flush) begin
        model_q.delete();
      end else if (bus.wr_en && size_before < DEPTH) begin
        model_q.push_back(bus.wr_data);
      end
      check_output("count", bus.count, model_q.size());
      check_output("empty", bus.empty, 32'(model_q.size() == 0));
      check_output("full", bus.full, 32'(model_q.size() == DEPTH));
      prev_start = bus.tx_start;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lat_vec_t   lat_tab[4];
    logic [7:0] exp[$];
    int         base;
    int         n;

    lat_tab[0] = '{8'h55, 1, 8'h55};
    lat_tab[1] = '{8'h00, 1, 8'h00};
    lat_tab[2] = '{8'hFF, 1, 8'hFF};
    lat_tab[3] = '{8'hA5, 1, 8'hA5};

    rst_n       = 1'b1;
    force_busy  = 1'b0;
    tx_enable   = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.flush   = 1'b0;
`ifdef UART_TX_QUEUE_OVF_EN
    bus.ovf_clr = 1'b0;
`endif

    // Reset values, checked while reset is still held
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_tx_start", bus.tx_start, 0);
    check_output("rst_tx_data", bus.tx_data, 0);
    check_output("rst_count", bus.count, 0);
    check_output("rst_empty", bus.empty, 1);
    check_output("rst_full", bus.full, 0);
`ifdef UART_TX_QUEUE_OVF_EN
    check_output("rst_ovf", bus.ovf, 0);
    check_output("rst_drop_cnt", bus.drop_cnt, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "ABC" on consecutive cycles
    exp.delete();
    base = busy_pulses;
    for (int i = 0; i < 3; i++) begin
      drive_write(8'(8'h41 + i));
      exp.push_back(8'(8'h41 + i));
    end
    end_write();
    wait_idle(600);
    check_output("abc_busy_pulses", busy_pulses - base, 3);
    check_rx("abc", exp);

    // Single-write latency, table driven
    exp.delete();
    for (int i = 0; i < 4; i++) begin
      drive_write(lat_tab[i].data);
      end_write();
      #1;
      check_output("lat_count_n1", bus.count, lat_tab[i].exp_count);
      check_output("lat_start_n1", bus.tx_start, 0);
      @(negedge clk); #1;
      check_output("lat_start_n2", bus.tx_start, 1);
      check_output("lat_data_n2", bus.tx_data, lat_tab[i].exp_tx_data);
      check_output("lat_busy_n2", bus.tx_busy, 1);
      @(negedge clk); #1;
      check_output("lat_start_fall", bus.tx_start, 0);
      exp.push_back(lat_tab[i].exp_tx_data);
      wait_idle(300);
    end
    check_rx("latency", exp);

    // Fill to DEPTH with the transmitter held busy, then one more
    @(negedge clk);
    force_busy = 1'b1;
    exp.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive_write(8'(8'h60 + i));
      if (i < DEPTH) exp.push_back(8'(8'h60 + i));
      if (i == DEPTH) begin
        #1;
        check_output("full_after_last", bus.full, 1);
        check_output("count_after_last", bus.count, DEPTH);
      end
    end
    end_write();
    #1;
    check_output("full_after_drop", bus.full, 1);
    check_output("count_after_drop", bus.count, DEPTH);
`ifdef UART_TX_QUEUE_OVF_EN
    check_output("ovf_after_drop", bus.ovf, 1);
    check_output("drop_cnt_after_drop", bus.drop_cnt, 1);
    drive_write(8'hEE);
    bus.ovf_clr = 1'b1;
    end_write();
    bus.ovf_clr = 1'b0;
    #1;
    check_output("ovf_clr_wins", bus.ovf, 0);
    check_output("drop_cnt_clr_wins", bus.drop_cnt, 0);
    check_output("count_after_clr", bus.count, DEPTH);
`endif
    force_busy = 1'b0;
    wait_idle(DEPTH * 110 + 100);
    check_rx("full_order", exp);

    // 40 bytes in bursts of 10 while draining, crossing the pointer wrap
    exp.delete();
    for (int burst = 0; burst < 4; burst++) begin
      for (int i = 0; i < 10; i++) begin
        drive_write(8'(burst * 10 + i));
        exp.push_back(8'(burst * 10 + i));
      end
      end_write();
      repeat (800) @(negedge clk);
    end
    wait_idle(2000);
    check_rx("wrap", exp);

    // Flush (with a concurrent write) while the first byte is in S_WAIT
    exp.delete();
    exp.push_back(8'h71);
    for (int i = 0; i < 5; i++) drive_write(8'(8'h71 + i));
    end_write();
    n = 0;
    while (!(xmit_busy && !bus.tx_start) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("flush_reach_wait", 32'(n < 50), 1);
    base = start_count;
    drive_write(8'hEE);
    bus.flush = 1'b1;
    end_write();
    bus.flush = 1'b0;
    #1;
    check_output("flush_count", bus.count, 0);
    check_output("flush_empty", bus.empty, 1);
    check_output("flush_full", bus.full, 0);
    check_output("flush_tx_data_held", bus.tx_data, 8'h71);
    wait_idle(300);
    repeat (50) @(negedge clk);
    check_output("flush_no_new_start", start_count - base, 0);
    check_rx("flush", exp);

    // Asynchronous reset while a request is pending in S_REQ
    tx_enable = 1'b0;
    drive_write(8'h5A);
    drive_write(8'h5B);
    end_write();
    #1;
    check_output("rst_reach_req", bus.tx_start, 1);
    check_output("rst_pre_count", bus.count, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_tx_start", bus.tx_start, 0);
    check_output("async_tx_data", bus.tx_data, 0);
    check_output("async_count", bus.count, 0);
    check_output("async_empty", bus.empty, 1);
    check_output("async_full", bus.full, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    tx_enable = 1'b1;
    exp.delete();
    exp.push_back(8'h3C);
    drive_write(8'h3C);
    end_write();
    wait_idle(300);
    check_rx("after_reset", exp);

    // Randomized writes, flushes, busy stalls and clears against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_data = 8'($urandom);
      bus.flush   = ($urandom_range(0, 99) == 0);
      force_busy  = ($urandom_range(0, 7) == 0);
`ifdef UART_TX_QUEUE_OVF_EN
      bus.ovf_clr = ($urandom_range(0, 49) == 0);
`endif
    end
    @(negedge clk);
    bus.wr_en  = 1'b0;
    bus.flush  = 1'b0;
    force_busy = 1'b0;
`ifdef UART_TX_QUEUE_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    wait_idle(DEPTH * 110 + 300);
    rx_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
